ising_phase_sampler: RTL and testbench

Run controller and spin readout for the coupled-oscillator array. It holds the array in oscillator reset, then releases it for a programmed anneal interval. It then samples every spin's phase against spin 0 over a programmed window and publishes one majority-vote spin bit per oscillator, plus per-spin mismatch counts. It sits downstream of the coupled-cell array: it drives the array's `ising_rstn` and consumes the asynchronous phase outputs at the array edge.

---
 rtl/ising_phase_sampler_pkg.sv | 14 +
 rtl/ising_phase_sampler_phase_sync.sv | 22 ++
 rtl/ising_phase_sampler.sv | 144 ++++++++++++++
 tb/tb_ising_phase_sampler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ising_phase_sampler_pkg.sv
// Shared types for the Ising phase sampler: FSM state encoding and default widths.
package ising_phase_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/ising_phase_sampler_phase_sync.sv
// Two-flop synchronizer bringing the asynchronous oscillator phases into clk.
module phase_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync;

    // NOTE: no reset on purpose; the chain flushes itself in two cycles and a
    // reset here would only add a reset-to-async-path timing arc.
    always_ff @(posedge clk) begin
        meta <= d;
        sync <= meta;
    end

    assign q = sync;

endmodule

// File: rtl/ising_phase_sampler.sv
// Run controller for the coupled-oscillator array: reset, anneal, sample the
// phases against spin 0 and publish majority-vote spins plus mismatch counts.
module ising_phase_sampler
    import ising_phase_sampler_pkg::*;
#(
    parameter int N          = 8,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int RST_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 axi_rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [31:0]          cfg_run_cycles,
    input  logic [CNT_W-1:0]     cfg_sample_cycles,
    input  logic [N-1:0]         phase,
    output logic                 ising_rstn,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         spins,
    input  logic [$clog2(N)-1:0] rd_idx,
    output logic [CNT_W-1:0]     rd_count
);

    state_t                  state;
    state_t                  phase_next;
    logic                    phase_last;
    logic [31:0]             timer;
    logic [N-1:0]            sync;
    logic [N-1:0]            mismatch;
    logic [N-1:0]            spin_next;
    logic [N-1:0][CNT_W-1:0] bank;

    phase_sync #(.WIDTH(N)) u_phase_sync (
        .clk (clk),
        .d   (phase),
        .q   (sync)
    );

    assign mismatch = sync ^ {N{sync[0]}};

    // Zero-length anneal or window phases are skipped rather than entered.
    always_comb begin
        phase_last = 1'b0;
        phase_next = ST_IDLE;
        case (state)
            ST_RESET: begin
                phase_last = (timer == 32'(RST_CYCLES - 1));
                if (cfg_run_cycles != 32'd0)
                    phase_next = ST_RUN;
                else
                    phase_next = (cfg_sample_cycles == '0) ? ST_DONE : ST_SAMPLE;
            end
            ST_RUN: begin
                phase_last = (timer == cfg_run_cycles - 32'd1);
                phase_next = (cfg_sample_cycles == '0) ? ST_DONE : ST_SAMPLE;
            end
            ST_SAMPLE: begin
                phase_last = (timer == 32'(cfg_sample_cycles) - 32'd1);
                phase_next = ST_DONE;
            end
            default: ;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register in this
    // block sees the pre-edge value of state and timer.
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            state      <= ST_IDLE;
            timer      <= 32'd0;
            ising_rstn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RESET;
                        busy  <= 1'b1;
                        timer <= 32'd0;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    ising_rstn <= 1'b0;
                end
                default: begin
                    if (stop) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        ising_rstn <= 1'b0;
                    end else if (phase_last) begin
                        state      <= phase_next;
                        timer      <= 32'd0;
                        ising_rstn <= 1'b1;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_spin
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] count_q;

        // Working count is cleared throughout RESET/RUN so it is zero on SAMPLE entry.
        always_ff @(posedge clk) begin
            if (axi_rst) begin
                count   <= '0;
                count_q <= '0;
            end else begin
                if (state == ST_RESET || state == ST_RUN)
                    count <= '0;
                else if (state == ST_SAMPLE && mismatch[i])
                    count <= count + CNT_W'(1);
                if (state == ST_DONE)
                    count_q <= count;
            end
        end

        assign bank[i] = count_q;

        if (i == 0) begin : g_ref
            assign spin_next[i] = 1'b0;
        end else begin : g_cmp
            assign spin_next[i] = {count, 1'b0} > {1'b0, cfg_sample_cycles};
        end
    end

    always_ff @(posedge clk) begin
        if (axi_rst)
            spins <= '0;
        else if (state == ST_DONE)
            spins <= spin_next;
    end

    assign rd_count = bank[rd_idx];

endmodule

// File: tb/tb_ising_phase_sampler.sv
// Directed bench for ising_phase_sampler: table of full runs plus stop and reset sequences.
module tb_ising_phase_sampler;

    localparam int N     = 4;
    localparam int CNT_W = 16;
    localparam int RST   = 4;

    logic             clk = 1'b0;
    logic             axi_rst;
    logic             start;
    logic             stop;
    logic [31:0]      cfg_run_cycles;
    logic [CNT_W-1:0] cfg_sample_cycles;
    logic [N-1:0]     phase;
    logic             ising_rstn;
    logic             busy;
    logic             done;
    logic [N-1:0]     spins;
    logic [1:0]       rd_idx;
    logic [CNT_W-1:0] rd_count;

    ising_phase_sampler #(.N(N), .CNT_W(CNT_W), .RST_CYCLES(RST)) dut (
        .clk               (clk),
        .axi_rst           (axi_rst),
        .start             (start),
        .stop              (stop),
        .cfg_run_cycles    (cfg_run_cycles),
        .cfg_sample_cycles (cfg_sample_cycles),
        .phase             (phase),
        .ising_rstn        (ising_rstn),
        .busy              (busy),
        .done              (done),
        .spins             (spins),
        .rd_idx            (rd_idx),
        .rd_count          (rd_count)
    );

    always #5 clk = ~clk;

    typedef enum int {PH_TOGGLE, PH_TIE, PH_ALL} ph_mode_t;

    typedef struct {
        ph_mode_t   mode;
        int         run;
        int         samp;
        int         restart;
        bit         with_stop;
        int         exp_done;
        logic [3:0] exp_spins;
        int         exp_c1;
        int         exp_c2;
        int         exp_c3;
    } vec_t;

    int       n_checks = 0;
    int       n_bad    = 0;
    int       cyc      = 0;
    ph_mode_t mode     = PH_TOGGLE;
    vec_t     vecs[6];

    function automatic logic [N-1:0] phase_of(ph_mode_t m, int c);
        logic p0;
        logic t;
        p0 = ((c / 3) % 2) == 1;
        t  = (c <= 16);
        case (m)
            PH_TOGGLE: return {p0, ~p0, p0, ~p0};
            PH_TIE:    return {1'b0, 1'b1, t, 1'b0};
            default:   return 4'b1110;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        phase = phase_of(mode, cyc);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_count(input int idx, input int exp, input string name);
        rd_idx = 2'(idx);
        #1;
        check(name, 32'(rd_count), exp);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int  done_cyc;
        int  rise;
        int  high;
        mode              = v.mode;
        cyc               = 0;
        cfg_run_cycles    = v.run;
        cfg_sample_cycles = CNT_W'(v.samp);
        phase             = phase_of(mode, 0);
        start             = 1'b1;
        stop              = v.with_stop;
        done_cyc          = -1;
        rise              = -1;
        high              = 0;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check($sformatf("v%0d busy@1", k), busy, 1);
        check($sformatf("v%0d rstn@1", k), ising_rstn, 0);
        while (1) begin
            if (ising_rstn) begin
                high++;
                if (rise < 0) rise = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc >= v.exp_done + 5) break;
            start = (cyc == v.restart);
            step();
            start = 1'b0;
        end
        check($sformatf("v%0d done cycle", k), done_cyc, v.exp_done);
        check($sformatf("v%0d rstn rise", k), rise, 1 + RST);
        check($sformatf("v%0d rstn high cycles", k), high, v.run + v.samp + 1);
        check($sformatf("v%0d spins", k), spins, v.exp_spins);
        step();
        check($sformatf("v%0d done pulse width", k), done, 0);
        check($sformatf("v%0d busy after done", k), busy, 0);
        check_count(1, v.exp_c1, $sformatf("v%0d count1", k));
        check_count(2, v.exp_c2, $sformatf("v%0d count2", k));
        check_count(3, v.exp_c3, $sformatf("v%0d count3", k));
    endtask

    initial begin
        bit saw_done;
        axi_rst           = 1'b1;
        start             = 1'b0;
        stop              = 1'b0;
        cfg_run_cycles    = 32'd0;
        cfg_sample_cycles = '0;
        phase             = '0;
        rd_idx            = '0;

        vecs[0] = '{PH_TOGGLE, 10, 8,     0, 1'b0, 24,    4'b1010, 8,     0,     8};
        vecs[1] = '{PH_TIE,    10, 8,     0, 1'b0, 24,    4'b0100, 4,     8,     0};
        vecs[2] = '{PH_TOGGLE, 0,  0,     0, 1'b0, 6,     4'b0000, 0,     0,     0};
        vecs[3] = '{PH_TOGGLE, 3,  7,     0, 1'b1, 16,    4'b1010, 7,     0,     7};
        vecs[4] = '{PH_TOGGLE, 10, 8,     8, 1'b0, 24,    4'b1010, 8,     0,     8};
        vecs[5] = '{PH_ALL,    2,  65535, 0, 1'b0, 65543, 4'b1110, 65535, 65535, 65535};

        repeat (3) step();
        axi_rst = 1'b0;
        step();
        check("reset rstn", ising_rstn, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset spins", spins, 0);
        check_count(1, 0, "reset count1");

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort during a long anneal: results from the previous run stay put.
        mode              = PH_TOGGLE;
        cyc               = 0;
        cfg_run_cycles    = 32'd100;
        cfg_sample_cycles = CNT_W'(8);
        start             = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 20) step();
        check("stop busy before", busy, 1);
        check("stop rstn before", ising_rstn, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop busy@21", busy, 0);
        check("stop rstn@21", ising_rstn, 0);
        check("stop spins kept", spins, 4'b1110);
        saw_done = 1'b0;
        for (int j = 0; j < 130; j++) begin
            if (done || busy) saw_done = 1'b1;
            step();
        end
        check("stop no done/busy", saw_done, 0);
        check_count(1, 65535, "stop count1 kept");

        // Reset asserted mid-SAMPLE (SAMPLE spans cycles 7..26 here).
        mode              = PH_ALL;
        cyc               = 0;
        cfg_run_cycles    = 32'd2;
        cfg_sample_cycles = CNT_W'(20);
        start             = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 10) step();
        check("mid-sample busy", busy, 1);
        axi_rst = 1'b1;
        step();
        axi_rst = 1'b0;
        check("rst rstn", ising_rstn, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst spins", spins, 0);
        check_count(1, 0, "rst count1");
        check_count(3, 0, "rst count3");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
